// File: rtl/axis_packet_arbiter_if.sv
// axis_packet_arbiter_if: stream bundle for the packet arbiter.
// Carries the M requester lanes, the shared output stream and the grant flag.
// master = arbiter side (drives s_tready and the m_* output stream),
// slave  = environment side (drives the requester lanes and m_tready).
interface axis_packet_arbiter_if #(
    parameter int N = 4,
    parameter int M = 4,
    parameter int I = 2
);
    logic [M-1:0]       s_tvalid;
    logic [M-1:0]       s_tready;
    logic [M*8*N-1:0]   s_tdata;
    logic [M-1:0]       s_tlast;
    logic               m_tvalid;
    logic               m_tready;
    logic [8*N-1:0]     m_tdata;
    logic               m_tlast;
    logic [I-1:0]       m_tid;
    logic               grant_active;

    modport master (
        input  s_tvalid, s_tdata, s_tlast, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tlast, m_tid, grant_active
    );

    modport slave (
        output s_tvalid, s_tdata, s_tlast, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tlast, m_tid, grant_active
    );
endinterface

// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter: per-packet round-robin arbiter sharing one AXI4-Stream
// output between M requesters. A grant is held from arbitration until the TLAST
// beat of that packet is accepted; m_tid carries the granted lane index.
// Optional: define AXIS_PACKET_ARBITER_REGSLICE_EN to put a 2-entry skid slice
// on the output (registered outputs, 1-cycle latency, full throughput).
module axis_packet_arbiter #(
    parameter int N = 4,
    parameter int M = 4,
    parameter int I = 2
) (
    input logic                   ACLK,
    input logic                   ARESETn,
    axis_packet_arbiter_if.master bus
);
    localparam int DW = 8 * N;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [I-1:0]   grant_q, grant_d;
    logic [I-1:0]   rr_ptr_q, rr_ptr_d;
    logic [I-1:0]   ptr_after_grant;
    logic [I-1:0]   req_idx;
    logic           req_found;
    logic [M-1:0]   rot;
    logic [M-1:0]   lane_sel;
    logic           busy;
    logic           g_valid;
    logic           g_last;
    logic [DW-1:0]  g_data;
    logic           eop;

    assign busy             = (state_q == BUSY);
    assign bus.grant_active = busy;
    assign ptr_after_grant  = (int'(grant_q) == M - 1) ? '0 : grant_q + 1'b1;

    // Decode the held grant into a lane select and mux that lane's stream fields.
    always_comb begin
        lane_sel = '0;
        g_valid  = 1'b0;
        g_last   = 1'b0;
        g_data   = '0;
        for (int k = 0; k < M; k++) begin
            if (grant_q == I'(k)) begin
                lane_sel[k] = 1'b1;
                g_valid     = bus.s_tvalid[k];
                g_last      = bus.s_tlast[k];
                g_data      = bus.s_tdata[k*DW +: DW];
            end
        end
    end

    // Rotate requests so bit 0 is rr_ptr, then take the lowest set bit.
    always_comb begin
        rot       = M'({bus.s_tvalid, bus.s_tvalid} >> rr_ptr_q);
        req_found = 1'b0;
        req_idx   = '0;
        for (int k = M - 1; k >= 0; k--) begin
            if (rot[k]) begin
                req_found = 1'b1;
                req_idx   = (int'(rr_ptr_q) + k >= M) ? I'(int'(rr_ptr_q) + k - M)
                                                      : I'(int'(rr_ptr_q) + k);
            end
        end
    end

    // Arbitration state: held grant, round-robin pointer, IDLE/BUSY.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Next state: grant in IDLE, release on the accepted TLAST beat.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (req_found) begin
                    grant_d = req_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (eop) begin
                    rr_ptr_d = ptr_after_grant;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef AXIS_PACKET_ARBITER_REGSLICE_EN
    typedef struct packed {
        logic [I-1:0]  tid;
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    beat_t       ent_q [2];
    beat_t       in_beat;
    logic [1:0]  cnt_q;
    logic        room;
    logic        push;
    logic        pop;

    assign in_beat = '{tid: grant_q, last: g_last, data: g_data};
    assign room    = (cnt_q != 2'd2);
    assign push    = busy & g_valid & room;
    assign pop     = (cnt_q != 2'd0) & bus.m_tready;
    // Packet ends when the TLAST beat enters the slice, not when it leaves.
    assign eop     = push & g_last;

    assign bus.s_tready = lane_sel & {M{busy & room}};
    assign bus.m_tvalid = (cnt_q != 2'd0);
    assign bus.m_tdata  = ent_q[0].data;
    assign bus.m_tlast  = ent_q[0].last;
    assign bus.m_tid    = ent_q[0].tid;

    // Two-entry skid FIFO; entry 0 is the head driving the output.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            ent_q[0] <= '0;
            ent_q[1] <= '0;
            cnt_q    <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) ent_q[0] <= in_beat;
                    else               ent_q[1] <= in_beat;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    ent_q[0] <= ent_q[1];
                    cnt_q    <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        ent_q[0] <= in_beat;
                    end else begin
                        ent_q[0] <= ent_q[1];
                        ent_q[1] <= in_beat;
                    end
                end
                default: ;
            endcase
        end
    end
`else
    // Straight combinational path from the granted lane; zero latency.
    assign bus.s_tready = lane_sel & {M{busy & bus.m_tready}};
    assign bus.m_tvalid = busy & g_valid;
    assign bus.m_tdata  = busy ? g_data : '0;
    assign bus.m_tlast  = busy & g_last;
    assign bus.m_tid    = busy ? grant_q : '0;
    assign eop          = busy & g_valid & bus.m_tready & g_last;
`endif

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// tb_axis_packet_arbiter: directed phases plus randomized traffic, checked
// against a packet-level round-robin reference model.
module tb_axis_packet_arbiter;
    localparam int N  = 4;
    localparam int M  = 4;
    localparam int I  = 2;
    localparam int DW = 8 * N;

    logic ACLK    = 1'b0;
    logic ARESETn = 1'b1;

    axis_packet_arbiter_if #(.N(N), .M(M), .I(I)) bus ();

    axis_packet_arbiter #(.N(N), .M(M), .I(I)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .bus     (bus)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;

    // Per-input traffic: flat beat lists plus packet lengths.
    logic [DW-1:0] bd   [M][64];
    logic          bl   [M][64];
    int            nb   [M];
    int            pos  [M];
    int            plen [M][16];
    int            np   [M];

    logic [I+DW:0] ex [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_traffic();
        for (int k = 0; k < M; k++) begin
            nb[k] = 0; pos[k] = 0; np[k] = 0;
        end
    endtask

    task automatic add_pkt(input int k, input int len, input logic [DW-1:0] d0, input bit rnd);
        plen[k][np[k]] = len;
        np[k]++;
        for (int b = 0; b < len; b++) begin
            bd[k][nb[k]] = rnd ? DW'($urandom) : DW'(d0 * (b + 1));
            bl[k][nb[k]] = (b == len - 1);
            nb[k]++;
        end
    endtask

    task automatic idle_inputs();
        bus.s_tvalid = '0;
        bus.s_tlast  = '0;
        bus.s_tdata  = '0;
        bus.m_tready = 1'b1;
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        idle_inputs();
        repeat (2) @(posedge ACLK);
        #1 ARESETn = 1'b1;
    endtask

    // Advance sources past accepted beats and present the next one; valid is
    // held until accepted, packet-start beats are always offered when pending.
    task automatic drive(input logic [M-1:0] hs, input bit gaps, input bit rnd_ready);
        bit start;
        for (int k = 0; k < M; k++) begin
            if (hs[k]) pos[k]++;
            if (!bus.s_tvalid[k] || hs[k]) begin
                if (pos[k] < nb[k]) begin
                    if (pos[k] == 0) start = 1'b1;
                    else             start = bl[k][pos[k]-1];
                    bus.s_tvalid[k]         = start || !gaps || ($urandom_range(3) != 0);
                    bus.s_tdata[k*DW +: DW] = bd[k][pos[k]];
                    bus.s_tlast[k]          = bl[k][pos[k]];
                end else begin
                    bus.s_tvalid[k] = 1'b0;
                    bus.s_tlast[k]  = 1'b0;
                end
            end
        end
        bus.m_tready = rnd_ready ? ($urandom_range(3) != 0) : 1'b1;
    endtask

    // Reference: whole packets leave in round-robin order over pending inputs.
    task automatic build_expect(input int start_ptr);
        int p [M];
        int b [M];
        int ptr, g, c;
        ex.delete();
        for (int k = 0; k < M; k++) begin p[k] = 0; b[k] = 0; end
        ptr = start_ptr;
        while (1) begin
            g = -1;
            for (int k = 0; k < M; k++) begin
                c = (ptr + k) % M;
                if (g < 0 && p[c] < np[c]) g = c;
            end
            if (g < 0) break;
            for (int j = 0; j < plen[g][p[g]]; j++) begin
                ex.push_back({I'(g), bl[g][b[g]], bd[g][b[g]]});
                b[g]++;
            end
            p[g]++;
            ptr = (g + 1) % M;
        end
    endtask

    task automatic run(input int start_ptr, input int budget, input bit gaps,
                       input bit rnd_ready, output int span);
        int cyc = 0, first = -1, lastc = -1, oidx = 0;
        bit stall = 0, eop_prev = 0;
        logic [I+DW:0] held, obs;
        logic [M-1:0]  hs;
        held = '0;
        build_expect(start_ptr);
        drive('0, gaps, rnd_ready);
        while (oidx < ex.size() && cyc < budget) begin
            @(negedge ACLK);
            obs = {bus.m_tid, bus.m_tlast, bus.m_tdata};
            if (eop_prev) check("bubble_after_last", bus.grant_active, 0);
            if (stall)    check("stall_hold", {bus.m_tvalid, obs}, {1'b1, held});
            check("ready_onehot", ($countones(bus.s_tready) <= 1), 1);
            hs       = bus.s_tvalid & bus.s_tready;
            eop_prev = |(hs & bus.s_tlast);
            if (bus.m_tvalid && bus.m_tready) begin
                check("beat", obs, ex[oidx]);
                oidx++;
                if (first < 0) first = cyc;
                lastc = cyc;
            end
            stall = bus.m_tvalid && !bus.m_tready;
            held  = obs;
            @(posedge ACLK);
            #1 drive(hs, gaps, rnd_ready);
            cyc++;
        end
        check("all_beats", oidx, ex.size());
        span = lastc - first;
    endtask

    initial begin
        int span, cnt, t;
        logic [M-1:0] hs;

        // Asynchronous reset, checked before the first clock edge.
        idle_inputs();
        #2 ARESETn = 1'b0;
        #1;
        check("rst_m_tvalid", bus.m_tvalid, 0);
        check("rst_s_tready", bus.s_tready, 0);
        check("rst_grant_active", bus.grant_active, 0);
        check("rst_m_tlast", bus.m_tlast, 0);
        check("rst_m_tdata", bus.m_tdata, 0);
        check("rst_m_tid", bus.m_tid, 0);
        do_reset();

        // Input 1: three beats 0x11111111, 0x22222222, 0x33333333.
        clear_traffic();
        add_pkt(1, 3, 32'h11111111, 1'b0);
        run(0, 100, 1'b0, 1'b0, span);

        // rr_ptr is now 2: input 2 goes first, input 0 waits and wins on wrap.
        clear_traffic();
        add_pkt(0, 2, '0, 1'b1);
        add_pkt(2, 4, '0, 1'b1);
        run(2, 100, 1'b0, 1'b0, span);

        // All inputs busy with 2-beat packets: order 0,1,2,3,0, one bubble each.
        do_reset();
        clear_traffic();
        for (int k = 0; k < M; k++) add_pkt(k, 2, '0, 1'b1);
        add_pkt(0, 2, '0, 1'b1);
        run(0, 200, 1'b0, 1'b0, span);
        check("span_5pkts", span, 13);

        // Randomized traffic with valid gaps and output back-pressure.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            clear_traffic();
            for (int k = 0; k < M; k++)
                for (int j = 0; j < int'($urandom_range(3, 1)); j++)
                    add_pkt(k, int'($urandom_range(4, 1)), '0, 1'b1);
            run(0, 3000, 1'b1, 1'b1, span);
        end

        // Reset during beat 2 of a 5-beat packet on input 2.
        do_reset();
        clear_traffic();
        add_pkt(2, 5, '0, 1'b1);
        drive('0, 1'b0, 1'b0);
        cnt = 0;
        t   = 0;
        while (cnt < 2 && t < 50) begin
            @(negedge ACLK);
            hs = bus.s_tvalid & bus.s_tready;
            if (hs[2]) cnt++;
            @(posedge ACLK);
            #1 drive(hs, 1'b0, 1'b0);
            t++;
        end
        check("reached_beat2", cnt, 2);
        ARESETn = 1'b0;
        bus.s_tvalid[0]    = 1'b1;
        bus.s_tdata[DW-1:0] = 32'hA0A0A0A0;
        bus.s_tlast[0]     = 1'b1;
        #2;
        check("midrst_m_tvalid", bus.m_tvalid, 0);
        check("midrst_s_tready", bus.s_tready, 0);
        check("midrst_grant_active", bus.grant_active, 0);
        check("midrst_m_tdata", bus.m_tdata, 0);
        @(posedge ACLK);
        #1 ARESETn = 1'b1;
        t = 0;
        while (!bus.m_tvalid && t < 20) begin
            @(negedge ACLK);
            t++;
        end
        check("postrst_valid", bus.m_tvalid, 1);
        check("postrst_tid", bus.m_tid, 0);
        check("postrst_data", bus.m_tdata, 32'hA0A0A0A0);
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net in case the bench itself stops making progress.
    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
